regfile_sb: RTL and testbench

Parametrised integer register file for the RISC-V core, successor to the fixed 32x32 regfile. It provides:
- two asynchronous read ports and one synchronous write port;
- optional write-to-read bypass;
- a per-register busy scoreboard for pipeline hazard detection;
- a post-reset sequential clear state machine, so no wide reset fan-out is needed on the array.
It sits between decode (read/issue) and writeback (write).

---
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with bypass, busy scoreboard and a post-reset sequential clear.
// Index 0 reads as zero. The array has no reset; a CLEAR walk zeroes x1..x(NREG-1)
// one entry per clock before the block reports ready.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ready,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] rd_data,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rd_busy,
  input  logic            flush
);

  localparam bit BYP = (BYPASS != 0);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, busy_nxt;

  logic run;
  logic wr_run;
  logic iss_run;
  logic byp1, byp2;

  assign run     = (state == S_RUN);
  assign wr_run  = run & we & (rd != '0);
  assign iss_run = run & issue_valid & (issue_rd != '0);

  // ready comes straight from the state flop, so it is glitch-free
  assign ready = run;

  // State register; reset restarts the clear walk from any state
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  // Next state: leave CLEAR on the edge that zeroes the last register
  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_cnt == AW'(NREG - 1)) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Clear counter starts at 1 because x0 is never stored
  always_ff @(posedge clk) begin
    if (!rst_n)                clr_cnt <= AW'(1);
    else if (state == S_CLEAR) clr_cnt <= clr_cnt + AW'(1);
  end

  // Array write: zeroing walk during CLEAR, writeback port during RUN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_CLEAR) regs[clr_cnt] <= '0;
      else if (wr_run)      regs[rd]      <= rd_data;
    end
  end

  // Scoreboard next value: flush, then writeback clear, then issue set (issue wins)
  always_comb begin
    busy_nxt = busy;
    if (flush)   busy_nxt           = '0;
    if (wr_run)  busy_nxt[rd]       = 1'b0;
    if (iss_run) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; only updates while running
  always_ff @(posedge clk) begin
    if (!rst_n)   busy <= '0;
    else if (run) busy <= busy_nxt;
  end

  // A same-cycle writeback to the read index is forwarded only in bypass builds
  assign byp1 = BYP & we & (rd == rs1) & (rd != '0);
  assign byp2 = BYP & we & (rd == rs2) & (rd != '0);

  assign rs1_data = (!run || rs1 == '0) ? '0 : (byp1 ? rd_data : regs[rs1]);
  assign rs2_data = (!run || rs2 == '0) ? '0 : (byp2 ? rd_data : regs[rs2]);

  assign rs1_busy = run & busy[rs1] & ~byp1;
  assign rs2_busy = run & busy[rs2] & ~byp2;
  assign rd_busy  = run & busy[issue_rd];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypass and one non-bypass instance driven in lockstep,
// directed scenarios followed by randomized traffic against a behavioural model.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic            rst_n, we, issue_valid, flush;
  logic [AW-1:0]   rd, rs1, rs2, issue_rd;
  logic [XLEN-1:0] rd_data;

  logic            ready_a, rs1_busy_a, rs2_busy_a, rd_busy_a;
  logic [XLEN-1:0] rs1_data_a, rs2_data_a;
  logic            ready_b, rs1_busy_b, rs2_busy_b, rd_busy_b;
  logic [XLEN-1:0] rs1_data_b, rs2_data_b;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ready(ready_a), .we(we), .rd(rd), .rd_data(rd_data),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data_a), .rs2_data(rs2_data_a),
    .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .rd_busy(rd_busy_a), .flush(flush));

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(ready_b), .we(we), .rd(rd), .rd_data(rd_data),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
    .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .rd_busy(rd_busy_b), .flush(flush));

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: register contents, set of busy indices, run flag, edges spent clearing
  logic [XLEN-1:0] mem [NREG];
  bit              mbusy [NREG];
  bit              m_run = 1'b0;
  int              m_clr = 0;
  bit              chk_en = 1'b0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] idx, input bit byp);
    if (!m_run || idx == 0)           return '0;
    if (byp && we && rd == idx)       return rd_data;
    return mem[idx];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] idx, input bit byp);
    bit resolved;
    resolved = byp && we && rd == idx && rd != 0;
    return m_run && mbusy[idx] && !resolved;
  endfunction

  task automatic check_outputs();
    if (chk_en) begin
      check("ready_a",    XLEN'(ready_a),    XLEN'(m_run));
      check("ready_b",    XLEN'(ready_b),    XLEN'(m_run));
      check("rs1_data_a", rs1_data_a,        exp_data(rs1, 1'b1));
      check("rs2_data_a", rs2_data_a,        exp_data(rs2, 1'b1));
      check("rs1_data_b", rs1_data_b,        exp_data(rs1, 1'b0));
      check("rs2_data_b", rs2_data_b,        exp_data(rs2, 1'b0));
      check("rs1_busy_a", XLEN'(rs1_busy_a), XLEN'(exp_busy(rs1, 1'b1)));
      check("rs2_busy_a", XLEN'(rs2_busy_a), XLEN'(exp_busy(rs2, 1'b1)));
      check("rs1_busy_b", XLEN'(rs1_busy_b), XLEN'(exp_busy(rs1, 1'b0)));
      check("rs2_busy_b", XLEN'(rs2_busy_b), XLEN'(exp_busy(rs2, 1'b0)));
      check("rd_busy_a",  XLEN'(rd_busy_a),  XLEN'(m_run && mbusy[issue_rd]));
      check("rd_busy_b",  XLEN'(rd_busy_b),  XLEN'(m_run && mbusy[issue_rd]));
    end
  endtask

  // Model state change at a rising edge, from the inputs held across it
  task automatic model_edge();
    bit nb [NREG];
    if (!rst_n) begin
      m_run = 1'b0;
      m_clr = 0;
      for (int i = 0; i < NREG; i++) mbusy[i] = 1'b0;
    end else if (!m_run) begin
      m_clr++;
      if (m_clr == NREG - 1) begin
        m_run = 1'b1;
        for (int i = 0; i < NREG; i++) mem[i] = '0;
      end
    end else begin
      if (we && rd != 0) mem[rd] = rd_data;
      for (int i = 1; i < NREG; i++) begin
        if (issue_valid && issue_rd == i)                 nb[i] = 1'b1;
        else if (flush || (we && rd == i))                nb[i] = 1'b0;
        else                                              nb[i] = mbusy[i];
      end
      nb[0] = 1'b0;
      for (int i = 0; i < NREG; i++) mbusy[i] = nb[i];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    we = 1'b0; issue_valid = 1'b0; flush = 1'b0;
  endtask

  // Run until ready, bounded; returns edges taken after the current point
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready_a && n < 100) begin
      cycle();
      n++;
    end
    check(tag, XLEN'(n), XLEN'(NREG - 1));
  endtask

  initial begin
    rst_n = 1'b0; quiet();
    rd = '0; rd_data = '0; rs1 = '0; rs2 = '0; issue_rd = '0;

    // Reset held for two edges
    @(posedge clk); model_edge(); #1;
    chk_en = 1'b1;
    cycle();

    // Clear sequence with writes, issues and flush driven but ignored
    rst_n = 1'b1;
    we = 1'b1; rd = 5'd3; rd_data = 32'hDEADBEEF;
    issue_valid = 1'b1; issue_rd = 5'd4; rs1 = 5'd5; rs2 = 5'd3;
    wait_ready("clear_len");
    quiet();
    #2;
    check("x5_after_clear", rs1_data_a, 32'h0);
    check("x3_not_written", rs2_data_a, 32'h0);
    check("x4_not_busy",    XLEN'(rd_busy_a), 32'h0);
    cycle();

    // Write and read
    we = 1'b1; rd = 5'd10; rd_data = 32'h12345678; cycle();
    rd = 5'd7; rd_data = 32'hFFFFFFFF; cycle();
    quiet(); rs1 = 5'd10; rs2 = 5'd7; #2;
    check("rd_x10", rs1_data_a, 32'h12345678);
    check("rd_x7",  rs2_data_b, 32'hFFFFFFFF);
    cycle();
    we = 1'b1; rd = 5'd0; rd_data = 32'h11111111; rs1 = 5'd0; cycle();
    quiet(); #2;
    check("rd_x0", rs1_data_a, 32'h0);
    cycle();

    // Bypass versus no bypass
    we = 1'b1; rd = 5'd14; rd_data = 32'h22222222; rs1 = 5'd14; #2;
    check("byp_on",  rs1_data_a, 32'h22222222);
    check("byp_off", rs1_data_b, 32'h0);
    cycle();
    quiet(); #2;
    check("byp_off_after", rs1_data_b, 32'h22222222);
    cycle();

    // Scoreboard set, resolve, and set-wins collision
    issue_valid = 1'b1; issue_rd = 5'd17; cycle();
    quiet(); rs2 = 5'd17; #2;
    check("busy17_set", XLEN'(rs2_busy_a), 32'h1);
    check("rd_busy17",  XLEN'(rd_busy_a),  32'h1);
    we = 1'b1; rd = 5'd17; rd_data = 32'h0BADF00D; #2;
    check("busy17_byp",   XLEN'(rs2_busy_a), 32'h0);
    check("busy17_nobyp", XLEN'(rs2_busy_b), 32'h1);
    cycle();
    quiet(); #2;
    check("busy17_clr", XLEN'(rs2_busy_a), 32'h0);
    issue_valid = 1'b1; issue_rd = 5'd17; we = 1'b1; rd = 5'd17; cycle();
    quiet(); #2;
    check("busy17_setwins", XLEN'(rs2_busy_b), 32'h1);
    cycle();

    // Flush with a same-cycle issue
    issue_valid = 1'b1; issue_rd = 5'd3;  cycle();
    issue_rd = 5'd9;  cycle();
    issue_rd = 5'd20; cycle();
    flush = 1'b1; issue_rd = 5'd9; cycle();
    quiet();
    rs1 = 5'd3;  #1; check("flush_b3",  XLEN'(rs1_busy_a), 32'h0);
    rs1 = 5'd9;  #1; check("flush_b9",  XLEN'(rs1_busy_a), 32'h1);
    rs1 = 5'd20; #1; check("flush_b20", XLEN'(rs1_busy_a), 32'h0);
    rs1 = 5'd17; #1; check("flush_b17", XLEN'(rs1_busy_a), 32'h0);
    cycle();

    // Reset in RUN
    issue_valid = 1'b1; issue_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd5; cycle();
    quiet(); rst_n = 1'b0; cycle();
    rst_n = 1'b1; #2;
    check("rst_ready", XLEN'(ready_a), 32'h0);
    wait_ready("reclear_len");
    #2;
    check("x5_reset",    rs1_data_a, 32'h0);
    check("busy5_reset", XLEN'(rs2_busy_a), 32'h0);
    cycle();

    // Reset in the middle of CLEAR, with the counter at 12
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    repeat (11) cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    wait_ready("midclear_len");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      we          = 1'($urandom_range(0, 1));
      rd          = AW'($urandom_range(0, NREG - 1));
      rd_data     = $urandom;
      rs1         = ($urandom_range(0, 1) != 0) ? rd : AW'($urandom_range(0, NREG - 1));
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, NREG - 1));
      rs2         = ($urandom_range(0, 1) != 0) ? issue_rd : AW'($urandom_range(0, NREG - 1));
      flush       = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
